// File: rtl/uart_autobaud.sv
// Automatic baud-rate detector: times a 0x55 sync character on the raw rx line
// and produces a UART divisor (bit period = div+1 clocks).
module uart_autobaud #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned N_SYNC    = 2,
  parameter int unsigned MIN_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 uart_rx,
  output logic                 busy,
  output logic                 div_vld,
  output logic [DIV_WIDTH-1:0] div_out,
  output logic                 err
);

  localparam int unsigned CNT_W = DIV_WIDTH + 3;
  localparam int unsigned Q_W   = DIV_WIDTH + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_HIGH = 3'd1;
  localparam logic [2:0] ARM       = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] WAIT_STOP = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  logic [N_SYNC-1:0]    sync_q;
  logic                 rx_d_q;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           edges_q, edges_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 busy_q, busy_d;
  logic                 div_vld_q, div_vld_d;
  logic                 err_q, err_d;

  logic                 rx_s;
  logic                 fall;
  logic                 cnt_sat;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CNT_W:0]       m_sum;
  logic [Q_W-1:0]       q;
  logic [Q_W-1:0]       qm1;
  logic                 too_small;
  logic                 too_big;

  assign rx_s    = sync_q[N_SYNC-1];
  assign fall    = rx_d_q & ~rx_s;
  assign cnt_sat = &cnt_q;
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);

  // Eight bit times measured; round to nearest single bit time.
  assign m_sum     = {1'b0, cnt_q} + (CNT_W+1)'(4);
  assign q         = Q_W'(m_sum >> 3);
  assign qm1       = q - Q_W'(1);
  assign too_small = (q <= Q_W'(MIN_DIV));
  assign too_big   = qm1[DIV_WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edges_d   = edges_q;
    div_d     = div_q;
    div_vld_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!enable)   state_d = IDLE;
        else if (rx_s) state_d = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (fall) begin
          cnt_d   = CNT_W'(1);
          edges_d = 3'd1;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          // Saturation takes priority over a coincident falling edge.
          if (cnt_sat) begin
            err_d   = 1'b1;
            state_d = WAIT_STOP;
          end else if (fall) begin
            if (edges_q == 3'd4) begin
              if (too_small || too_big) begin
                err_d = 1'b1;
              end else begin
                div_vld_d = 1'b1;
                div_d     = qm1[DIV_WIDTH-1:0];
              end
              state_d = WAIT_STOP;
            end else begin
              edges_d = edges_q + 3'd1;
            end
          end
        end
      end
      WAIT_STOP: begin
        if (!enable)   state_d = IDLE;
        else if (rx_s) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      rx_d_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      edges_q   <= '0;
      div_q     <= '0;
      busy_q    <= 1'b0;
      div_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[N_SYNC-2:0], uart_rx};
      rx_d_q    <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edges_q   <= edges_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      div_vld_q <= div_vld_d;
      err_q     <= err_d;
    end
  end

  assign busy    = busy_q;
  assign div_vld = div_vld_q;
  assign div_out = div_q;
  assign err     = err_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Scoreboard bench for uart_autobaud; a narrower divisor keeps the
// saturation case short.
module tb_uart_autobaud;

  localparam int unsigned DW = 10;

  typedef struct packed {
    logic        is_err;
    logic [15:0] div;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          uart_rx;
  logic          busy;
  logic          div_vld;
  logic [DW-1:0] div_out;
  logic          err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   saw_idle = 0;

  uart_autobaud #(.DIV_WIDTH(DW), .N_SYNC(2), .MIN_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .uart_rx (uart_rx),
    .busy    (busy),
    .div_vld (div_vld),
    .div_out (div_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!busy) saw_idle = 1'b1;
    if (div_vld || err) begin
      check("vld_err_excl", 32'(div_vld & err), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({div_vld, err}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind_err", 32'(err), 32'(e.is_err));
        if (!e.is_err) check("div_out", 32'(div_out), 32'(e.div));
      end
    end
  end

  task automatic hold(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // 0x55 8N1; the first `ext` bit periods are stretched by one cycle.
  task automatic send_char(input int t, input int ext);
    logic [7:0] b;
    logic       v;
    b = 8'h55;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = 1'b1;
      else             v = b[i-1];
      hold(v, t + ((i < 8 && i < ext) ? 1 : 0));
    end
  endtask

  task automatic push(input logic is_err, input int div);
    exp_t e;
    e.is_err = is_err;
    e.div    = 16'(div);
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    uart_rx = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vld", 32'(div_vld), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_div", 32'(div_out), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal T=87
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("armed_busy", 32'(busy), 32'd1);
    saw_idle = 1'b0;
    push(1'b0, 86);
    send_char(87, 0);
    wait_drain(200);
    check("busy_dropped", 32'(saw_idle), 32'd1);
    check("div_hold_86", 32'(div_out), 32'd86);
    repeat (5) @(negedge clk);

    // Rounding boundary m=699 / m=700
    push(1'b0, 86);
    send_char(87, 3);
    wait_drain(200);
    repeat (5) @(negedge clk);
    push(1'b0, 87);
    send_char(87, 4);
    wait_drain(200);
    repeat (5) @(negedge clk);

    // Too fast: q-1=2 below MIN_DIV
    push(1'b1, 0);
    send_char(3, 0);
    wait_drain(200);
    check("div_kept_87", 32'(div_out), 32'd87);
    repeat (10) @(negedge clk);

    // Line stuck low until the counter saturates
    push(1'b1, 0);
    uart_rx = 1'b0;
    wait_drain(9000);
    repeat (3) @(negedge clk);
    check("sat_wait_stop_busy", 32'(busy), 32'd1);
    saw_idle = 1'b0;
    hold(1'b1, 10);
    check("sat_done_idle", 32'(saw_idle), 32'd1);
    check("div_kept_sat", 32'(div_out), 32'd87);
    repeat (10) @(negedge clk);

    // Abort after the 3rd falling edge
    hold(1'b0, 87);
    hold(1'b1, 87);
    hold(1'b0, 87);
    hold(1'b1, 87);
    hold(1'b0, 6);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_busy_hold", 32'(busy), 32'd0);
    enable = 1'b1;
    repeat (50) @(negedge clk);
    check("wait_high_busy", 32'(busy), 32'd1);
    hold(1'b1, 174);
    push(1'b0, 86);
    send_char(87, 0);
    wait_drain(200);
    check("rearm_div_86", 32'(div_out), 32'd86);
    repeat (5) @(negedge clk);

    // Reset in the middle of a measurement
    hold(1'b0, 87);
    hold(1'b1, 10);
    check("mid_measure_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_div", 32'(div_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_vld", 32'(div_vld), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
